// File: rtl/fabric_ingress_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fabric_ingress_arbiter_if                                       |
// | Purpose  : Bundles the request/grant and muxed-beat handshake signals      |
// |            shared between the fabric ingress arbiter and its ingress ports.|
// | Modports : master - arbiter side (drives grant, grant_valid, grant_idx,    |
// |                     frame_done, timeout_err)                               |
// |            slave  - port/mux side (drives en, req, beat_valid, beat_ready, |
// |                     beat_last)                                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface fabric_ingress_arbiter_if #(
  parameter int NUM_PORTS = 24,
  parameter int IDX_WIDTH = $clog2(NUM_PORTS)
);
  logic                 en;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_valid;
  logic [IDX_WIDTH-1:0] grant_idx;
  logic                 beat_valid;
  logic                 beat_ready;
  logic                 beat_last;
  logic                 frame_done;
  logic                 timeout_err;

  modport master (
    input  en, req, beat_valid, beat_ready, beat_last,
    output grant, grant_valid, grant_idx, frame_done, timeout_err
  );

  modport slave (
    output en, req, beat_valid, beat_ready, beat_last,
    input  grant, grant_valid, grant_idx, frame_done, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/fabric_ingress_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fabric_ingress_arbiter                                          |
// | Purpose  : Frame-granular round-robin arbiter sharing the switch-fabric    |
// |            forwarding pipeline between NUM_PORTS ingress ports. One port   |
// |            is granted at a time and keeps the grant until the last beat of |
// |            its frame is accepted downstream.                               |
// | Ports    : clk_fabric - fabric clock                                       |
// |            rst        - synchronous reset, active high                     |
// |            bus        - fabric_ingress_arbiter_if.master:                  |
// |                         en, req[NUM_PORTS], beat_valid/ready/last (in)     |
// |                         grant[NUM_PORTS], grant_valid, grant_idx,          |
// |                         frame_done, timeout_err (out, all registered)      |
// | Options  : FABRIC_ARB_TIMEOUT_EN - builds a stall watchdog that aborts a   |
// |            grant after TIMEOUT_CYCLES clocks without a beat handshake.     |
// |            Without it timeout_err stays 0 and a stalled grant is held.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fabric_ingress_arbiter #(
  parameter int NUM_PORTS      = 24,
  parameter int IDX_WIDTH      = $clog2(NUM_PORTS),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk_fabric,
  input  logic                    rst,
  fabric_ingress_arbiter_if.master bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_WIDTH-1:0] last_winner_q, last_winner_d;
  logic                 frame_done_q, frame_done_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 win_found;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 beat_hs;
  logic                 last_hs;

`ifdef FABRIC_ARB_TIMEOUT_EN
  localparam int STALL_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_W-1:0] stall_q, stall_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Port index 'off' positions after 'base', wrapped modulo NUM_PORTS.
  // NUM_PORTS need not be a power of two, so the wrap is explicit.
  function automatic logic [IDX_WIDTH-1:0] wrap_idx(
    input logic [IDX_WIDTH-1:0] base,
    input int                   off
  );
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_PORTS) begin
      sum = sum - NUM_PORTS;
    end
    return IDX_WIDTH'(sum);
  endfunction

  // Round-robin search starting just after the previous winner. Scanning the
  // offsets from farthest to nearest lets the nearest requester overwrite the
  // result, which gives the priority order without an early loop exit. An
  // offset of NUM_PORTS lands back on the previous winner itself, so a lone
  // requester always wins.
  always_comb begin : rr_search
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      if (bus.req[wrap_idx(last_winner_q, off)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(last_winner_q, off);
      end
    end
  end

  assign beat_hs = bus.beat_valid & bus.beat_ready;
  assign last_hs = beat_hs & bus.beat_last;

  always_comb begin : next_state
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    last_winner_d = last_winner_q;
    frame_done_d  = 1'b0;
    timeout_err_d = 1'b0;
`ifdef FABRIC_ARB_TIMEOUT_EN
    stall_d       = stall_q;
`endif

    case (state_q)
      IDLE: begin
        // Beat inputs are deliberately ignored here.
        if (bus.en && win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          grant_valid_d    = 1'b1;
          grant_idx_d      = win_idx;
          last_winner_d    = win_idx;
          state_d          = GRANT;
`ifdef FABRIC_ARB_TIMEOUT_EN
          stall_d          = '0;
`endif
        end
      end

      GRANT: begin
        // req and en are not looked at: the grant is frame-atomic.
        if (last_hs) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          frame_done_d  = 1'b1;
          state_d       = IDLE;
        end
`ifdef FABRIC_ARB_TIMEOUT_EN
        // A completing frame outranks the watchdog. last_winner keeps the
        // stalled port so it drops to lowest priority next round.
        else if (stall_q == STALL_LIMIT) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else if (beat_hs) begin
          stall_d = '0;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_fabric) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      last_winner_q <= IDX_WIDTH'(NUM_PORTS - 1);
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef FABRIC_ARB_TIMEOUT_EN
      stall_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      last_winner_q <= last_winner_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
`ifdef FABRIC_ARB_TIMEOUT_EN
      stall_q       <= stall_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.frame_done  = frame_done_q;
  // Never set without the watchdog, so this flop reduces to a constant 0.
  assign bus.timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fabric_ingress_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fabric_ingress_arbiter                                       |
// | Purpose  : Directed bench for fabric_ingress_arbiter. Stimulus pushes the  |
// |            expected grant / frame_done / timeout events into a queue; a    |
// |            monitor pops and compares whenever the DUT presents one.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fabric_ingress_arbiter;

  localparam int N  = 24;
  localparam int IW = $clog2(N);
  localparam int TO = 16;

  localparam int EV_GRANT   = 0;
  localparam int EV_DONE    = 1;
  localparam int EV_TIMEOUT = 2;

  typedef struct {
    int kind;
    int idx;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  logic clk = 1'b0;
  logic rst;
  logic prev_gv;

  always #5 clk = ~clk;

  fabric_ingress_arbiter_if #(.NUM_PORTS(N)) bus ();

  fabric_ingress_arbiter #(
    .NUM_PORTS      (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_fabric (clk),
    .rst        (rst),
    .bus        (bus)
  );

  function automatic string kname(input int kind);
    if (kind == EV_GRANT)   return "grant";
    if (kind == EV_DONE)    return "frame_done";
    return "timeout_err";
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic exp_ev(input int kind, input int idx);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind, input int idx, input logic [N-1:0] gvec);
    ev_t        e;
    logic [N-1:0] g;
    int         ei;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got %s idx=%0d, required no event (t=%0t)",
               kname(kind), kname(kind), idx, $time);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind) begin
      n_fail++;
      $display("FAIL event_kind: got %s idx=%0d, required %s idx=%0d (t=%0t)",
               kname(kind), idx, kname(e.kind), e.idx, $time);
      return;
    end
    if (kind == EV_GRANT) begin
      ei = e.idx;
      g  = '0;
      g[ei[IW-1:0]] = 1'b1;
      n_cmp++;
      if (idx != e.idx || gvec !== g) begin
        n_fail++;
        $display("FAIL grant_value: got idx=%0d grant=0x%06h, required idx=%0d grant=0x%06h (t=%0t)",
                 idx, gvec, e.idx, g, $time);
      end
    end
  endtask

  // Monitor: an event is a rising grant_valid, a frame_done pulse or a
  // timeout_err pulse; each must match the head of the expectation queue.
  always @(negedge clk) begin
    if (bus.timeout_err === 1'b1) check_event(EV_TIMEOUT, 0, bus.grant);
    if (bus.frame_done === 1'b1)  check_event(EV_DONE, 0, bus.grant);
    if (bus.grant_valid === 1'b1 && prev_gv !== 1'b1)
      check_event(EV_GRANT, int'(bus.grant_idx), bus.grant);
    prev_gv = bus.grant_valid;
  end

  task automatic beats_off();
    bus.beat_valid = 1'b0;
    bus.beat_ready = 1'b0;
    bus.beat_last  = 1'b0;
  endtask

  task automatic send_frame(input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      bus.beat_valid = 1'b1;
      bus.beat_ready = 1'b1;
      bus.beat_last  = (i == nbeats - 1);
      tick();
    end
    beats_off();
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (bus.grant_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    n_cmp++;
    if (bus.grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: grant_valid=%b after %0d cycles, required 1", name, bus.grant_valid, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.req = '0;
    beats_off();
    repeat (3) tick();

    // Reset state
    chk("rst_grant",       64'(bus.grant),       64'h0);
    chk("rst_grant_valid", 64'(bus.grant_valid), 64'h0);
    chk("rst_grant_idx",   64'(bus.grant_idx),   64'h0);
    chk("rst_frame_done",  64'(bus.frame_done),  64'h0);
    chk("rst_timeout_err", 64'(bus.timeout_err), 64'h0);
    rst = 1'b0;
    tick();
    chk("idle_grant_valid", 64'(bus.grant_valid), 64'h0);

    // Single requester, one-cycle grant latency, 3-beat frame
    exp_ev(EV_GRANT, 0);
    bus.req = 24'h000001;
    bus.en  = 1'b1;
    tick();
    chk("t1_latency_gv", 64'(bus.grant_valid), 64'h1);
    chk("t1_grant",      64'(bus.grant),       64'h1);
    bus.req = '0;
    exp_ev(EV_DONE, 0);
    send_frame(3);
    chk("t1_done_pulse", 64'(bus.frame_done),  64'h1);
    chk("t1_gv_drop",    64'(bus.grant_valid), 64'h0);
    tick();
    chk("t1_done_once",  64'(bus.frame_done),  64'h0);

    // All ports requesting, 1-beat frames: 0..23,0,1 every other cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < N + 2; k++) begin
      exp_ev(EV_GRANT, k % N);
      exp_ev(EV_DONE, 0);
    end
    bus.req        = '1;
    bus.beat_valid = 1'b1;
    bus.beat_ready = 1'b1;
    bus.beat_last  = 1'b1;
    repeat (2 * (N + 2)) tick();
    bus.req = '0;
    beats_off();
    tick();
    tick();
    chk("t2_drained", 64'(exp_q.size()), 64'h0);

    // Port 5, then {7,2}: 7 before 2 (wrap)
    exp_ev(EV_GRANT, 5);
    bus.req = 24'h000020;
    wait_grant("t3_wait_5");
    bus.req = 24'h000084;
    exp_ev(EV_DONE, 0);
    exp_ev(EV_GRANT, 7);
    send_frame(2);
    wait_grant("t3_wait_7");
    exp_ev(EV_DONE, 0);
    exp_ev(EV_GRANT, 2);
    send_frame(1);
    wait_grant("t3_wait_2");
    bus.req = '0;
    exp_ev(EV_DONE, 0);
    send_frame(2);
    tick();
    chk("t3_idx_hold", 64'(bus.grant_idx),   64'd2);
    chk("t3_idle",     64'(bus.grant_valid), 64'h0);

    // Mid-frame req/en changes on port 3, stalled last beat ignored
    exp_ev(EV_GRANT, 3);
    bus.req = 24'h000008;
    wait_grant("t4_wait_3");
    exp_ev(EV_DONE, 0);
    bus.beat_valid = 1'b1; bus.beat_ready = 1'b1; bus.beat_last = 1'b0;
    tick();
    bus.req = 24'h000200;
    bus.en  = 1'b0;
    tick();
    chk("t4_hold_idx", 64'(bus.grant_idx),   64'd3);
    bus.beat_ready = 1'b0; bus.beat_last = 1'b1;
    tick();
    chk("t4_stall_gv", 64'(bus.grant_valid), 64'h1);
    bus.beat_ready = 1'b1; bus.beat_last = 1'b0;
    tick();
    bus.beat_last = 1'b1;
    tick();
    chk("t4_done_gv",  64'(bus.grant_valid), 64'h0);
    bus.beat_valid = 1'b1; bus.beat_ready = 1'b1; bus.beat_last = 1'b1;
    repeat (5) tick();
    chk("t4_en_low_idle", 64'(bus.grant_valid), 64'h0);
    beats_off();
    exp_ev(EV_GRANT, 9);
    bus.en = 1'b1;
    wait_grant("t4_wait_9");
    bus.req = '0;
    exp_ev(EV_DONE, 0);
    send_frame(1);
    tick();

    // Reset in the middle of a frame (last-beat handshake in the reset cycle)
    exp_ev(EV_GRANT, 10);
    bus.req = '1;
    wait_grant("t5_wait_10");
    bus.beat_valid = 1'b1; bus.beat_ready = 1'b1; bus.beat_last = 1'b0;
    tick();
    rst = 1'b1;
    bus.beat_last = 1'b1;
    tick();
    chk("t5_rst_gv",    64'(bus.grant_valid), 64'h0);
    chk("t5_rst_grant", 64'(bus.grant),       64'h0);
    chk("t5_rst_idx",   64'(bus.grant_idx),   64'h0);
    chk("t5_rst_done",  64'(bus.frame_done),  64'h0);
    beats_off();
    exp_ev(EV_GRANT, 0);
    rst = 1'b0;
    wait_grant("t5_wait_0");
    bus.req = '0;
    exp_ev(EV_DONE, 0);
    send_frame(1);
    tick();

    // Stalled grant on port 4 with req {4,6}
    exp_ev(EV_GRANT, 4);
    bus.req = 24'h000050;
    wait_grant("t6_wait_4");
    bus.beat_valid = 1'b1; bus.beat_ready = 1'b0; bus.beat_last = 1'b0;
`ifdef FABRIC_ARB_TIMEOUT_EN
    exp_ev(EV_TIMEOUT, 0);
    exp_ev(EV_GRANT, 6);
    repeat (TO - 1) tick();
    chk("t6_pre_timeout_gv", 64'(bus.grant_valid), 64'h1);
    tick();
    chk("t6_timeout_pulse",  64'(bus.timeout_err), 64'h1);
    chk("t6_timeout_gv",     64'(bus.grant_valid), 64'h0);
    beats_off();
    wait_grant("t6_wait_6");
    bus.req = '0;
    exp_ev(EV_DONE, 0);
    send_frame(1);
    tick();
`else
    repeat (100) tick();
    chk("t6_held_gv",  64'(bus.grant_valid), 64'h1);
    chk("t6_held_idx", 64'(bus.grant_idx),   64'd4);
    chk("t6_no_timeout", 64'(bus.timeout_err), 64'h0);
    bus.req = '0;
    exp_ev(EV_DONE, 0);
    send_frame(1);
    tick();
`endif

    tick();
    chk("final_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
